// File: rtl/bus_pkg.sv
// Shared types and constants for the bus_responder data-side endpoint.
package bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam logic [31:0] IO_LED_OFS = 32'h0000_0000;
  localparam logic [31:0] IO_SW_OFS  = 32'h0000_0004;
  localparam logic [31:0] IO_CNT_OFS = 32'h0000_0008;

  localparam logic [31:0] ERR_RDATA  = 32'h0000_0000;

endpackage

// File: rtl/bus_responder_sp_ram.sv
// Synchronous single-port word RAM, read-before-write, no reset on contents.
module sp_ram #(
  parameter int WORDS = 1024
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(WORDS)-1:0] addr,
  input  logic [31:0]              wdata,
  output logic [31:0]              rdata
);

  logic [31:0] mem [WORDS];

  // Single access port: optional write plus registered read of the same word.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/bus_responder.sv
// Word-wide req/ack bus responder serving RAM and a small I/O window.
// Optional free-running cycle counter at IO_BASE+8 when BUS_RESP_COUNTER_EN is defined.
module bus_responder
  import bus_pkg::*;
#(
  parameter int          MEM_WORDS   = 1024,
  parameter int          WAIT_CYCLES = 1,
  parameter logic [31:0] IO_BASE     = 32'hFFFF_0000
) (
  input  logic        CLOCK_50,
  input  logic        KEY,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [9:0]  sw,
  output logic [31:0] rdata,
  output logic        ack,
  output logic        err,
  output logic [9:0]  led
);

  localparam int          AW        = $clog2(MEM_WORDS);
  localparam logic [32:0] RAM_BYTES = 33'(MEM_WORDS) * 33'd4;
  localparam logic [3:0]  WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_e      state_q, state_d;
  logic [3:0]  wait_q, wait_d;
  logic [31:0] addr_q, addr_d;
  logic        we_q, we_d;
  logic [31:0] wdata_q, wdata_d;
  logic [9:0]  led_q, led_d;
  logic [9:0]  sw_meta_q, sw_sync_q;
  logic        resp_err_q, resp_err_d;
  logic        resp_ram_q, resp_ram_d;
  logic [31:0] resp_io_q, resp_io_d;
  logic [31:0] rdata_q, rdata_d;
  logic        ack_q, ack_d;
  logic        err_q, err_d;
  logic [31:0] cnt_val_s;
  logic        cnt_hit_s;
  logic        enter_resp_s, aligned_s, ram_hit_s, led_hit_s, sw_hit_s, map_ok_s, ram_we_s;
  logic [31:0] ram_rdata_s;

  // FSM sequencing and request capture; the _d copies are the latched request.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    addr_d  = addr_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          addr_d  = addr;
          we_d    = we;
          wdata_d = wdata;
          if (WAIT_CYCLES > 0) begin
            state_d = ST_WAIT;
            wait_d  = WAIT_INIT;
          end else begin
            state_d = ST_RESP;
            wait_d  = 4'd0;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (wait_q == 4'd0) begin
          state_d = ST_RESP;
        end else begin
          wait_d = wait_q - 4'd1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef BUS_RESP_COUNTER_EN
  logic [31:0] cnt_q;

  // Free-running cycle counter, wraps naturally.
  always_ff @(posedge CLOCK_50 or negedge KEY) begin
    if (!KEY) begin
      cnt_q <= 32'd0;
    end else begin
      cnt_q <= cnt_q + 32'd1;
    end
  end

  assign cnt_val_s = cnt_q;
  assign cnt_hit_s = aligned_s && (addr_d == IO_BASE + IO_CNT_OFS);
`else
  assign cnt_val_s = 32'd0;
  assign cnt_hit_s = 1'b0;
`endif

  // Decode on the latched address; side effects happen only on the edge entering RESP.
  always_comb begin
    enter_resp_s = (state_d == ST_RESP);
    aligned_s    = (addr_d[1:0] == 2'b00);
    ram_hit_s    = aligned_s && ({1'b0, addr_d} < RAM_BYTES);
    led_hit_s    = aligned_s && (addr_d == IO_BASE + IO_LED_OFS);
    sw_hit_s     = aligned_s && (addr_d == IO_BASE + IO_SW_OFS);
    map_ok_s     = ram_hit_s || led_hit_s || sw_hit_s || cnt_hit_s;
    ram_we_s     = enter_resp_s && we_d && ram_hit_s;
    led_d        = led_q;
    resp_err_d   = resp_err_q;
    resp_ram_d   = resp_ram_q;
    resp_io_d    = resp_io_q;
    if (enter_resp_s) begin
      resp_err_d = !map_ok_s;
      resp_ram_d = ram_hit_s && !we_d;
      resp_io_d  = 32'd0;
      if (we_d) begin
        if (led_hit_s) begin
          led_d = wdata_d[9:0];
        end else begin
          led_d = led_q;
        end
      end else if (led_hit_s) begin
        resp_io_d = {22'd0, led_q};
      end else if (sw_hit_s) begin
        resp_io_d = {22'd0, sw_sync_q};
      end else if (cnt_hit_s) begin
        resp_io_d = cnt_val_s;
      end else begin
        resp_io_d = 32'd0;
      end
    end else begin
      resp_err_d = resp_err_q;
    end
  end

  // Response stage: ack/err/rdata pulse out on the edge leaving RESP.
  always_comb begin
    ack_d   = 1'b0;
    err_d   = 1'b0;
    rdata_d = rdata_q;
    if (state_q == ST_RESP) begin
      ack_d = 1'b1;
      err_d = resp_err_q;
      if (resp_err_q) begin
        rdata_d = ERR_RDATA;
      end else if (resp_ram_q) begin
        rdata_d = ram_rdata_s;
      end else begin
        rdata_d = resp_io_q;
      end
    end else begin
      rdata_d = rdata_q;
    end
  end

  // State registers; an async reset drops any request in flight.
  always_ff @(posedge CLOCK_50 or negedge KEY) begin
    if (!KEY) begin
      state_q    <= ST_IDLE;
      wait_q     <= 4'd0;
      addr_q     <= 32'd0;
      we_q       <= 1'b0;
      wdata_q    <= 32'd0;
      led_q      <= 10'd0;
      sw_meta_q  <= 10'd0;
      sw_sync_q  <= 10'd0;
      resp_err_q <= 1'b0;
      resp_ram_q <= 1'b0;
      resp_io_q  <= 32'd0;
      rdata_q    <= 32'd0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_q     <= wait_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      led_q      <= led_d;
      sw_meta_q  <= sw;
      sw_sync_q  <= sw_meta_q;
      resp_err_q <= resp_err_d;
      resp_ram_q <= resp_ram_d;
      resp_io_q  <= resp_io_d;
      rdata_q    <= rdata_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
    end
  end

  sp_ram #(.WORDS(MEM_WORDS)) u_ram (
    .clk   (CLOCK_50),
    .we    (ram_we_s),
    .addr  (addr_d[AW+1:2]),
    .wdata (wdata_d),
    .rdata (ram_rdata_s)
  );

  assign rdata = rdata_q;
  assign ack   = ack_q;
  assign err   = err_q;
  assign led   = led_q;

endmodule
